// File: rtl/pipe_pkg.sv
// State encoding shared by the skid buffer: bit 0 is out_valid, bit 1 is !in_ready,
// so both handshake outputs fall straight out of the state flops.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } pipe_state_e;

    function automatic logic [1:0] occ_of(input pipe_state_e s);
        case (s)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/reg_arstn_en.sv
// Enabled data register with async active-low reset to PRESET_VAL.
// Latency: q updates on the edge where en=1; no backpressure of its own.
module reg_arstn_en #(
    parameter int                DATA_W     = 20,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q <= PRESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready slice with registered data, valid and ready; one-cycle latency.
// Backpressure: second word parks in skid_q and in_ready drops until downstream drains it.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 20,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic              in_fire;
    logic              out_fire;
    logic              main_en;
    logic              skid_en;
    logic              main_sel_skid;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_en       = 1'b0;
        skid_en       = 1'b0;
        main_sel_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_en = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en = 1'b1;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    // main_q keeps the stale word; out_valid alone marks it dead
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_en       = 1'b1;
                    main_sel_skid = 1'b1;
                    state_d       = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = ~state_q[1];
        out_valid = state_q[0];
        occ       = occ_of(state_q);
    end

    assign main_d = main_sel_skid ? skid_q : in_data;

    reg_arstn_en #(
        .DATA_W     (DATA_W),
        .PRESET_VAL (PRESET_VAL)
    ) u_main (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (main_en),
        .d      (main_d),
        .q      (main_q)
    );

    reg_arstn_en #(
        .DATA_W     (DATA_W),
        .PRESET_VAL (PRESET_VAL)
    ) u_skid (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (skid_en),
        .d      (in_data),
        .q      (skid_q)
    );

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Bench for pipe_skid_buf: directed phases plus a random-stall phase, checked by a scoreboard.
module tb_pipe_skid_buf;

    localparam int         DW     = 8;
    localparam logic [7:0] PRESET = 8'hA5;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            out_cnt  = 0;
    int            in_cnt   = 0;
    bit            chk_inv  = 1'b0;
    logic [DW-1:0] exp_q[$];

    pipe_skid_buf #(
        .DATA_W     (DW),
        .PRESET_VAL (PRESET)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sample on the falling edge, pop before push so same-cycle traffic stays ordered
    always @(negedge clk) begin
        if (arst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {24'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    check("out_data_order", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
                end
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                in_cnt++;
            end
            if (chk_inv) begin
                check("inv_in_ready", {31'h0, in_ready}, {31'h0, occ != 2'd2});
                check("inv_out_valid", {31'h0, out_valid}, {31'h0, occ != 2'd0});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cnt;
        arst_n    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        // Reset without any clock edge
        #1 arst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_occ", {30'h0, occ}, 32'h0);
        check("rst_out_data", {24'h0, out_data}, {24'h0, PRESET});
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        // Streaming 01..10 with out_ready held high
        out_ready = 1'b1;
        start_cnt = out_cnt;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            step();
            check("stream_occ", {30'h0, occ}, 32'h1);
            check("stream_out_data", {24'h0, out_data}, i);
        end
        in_valid = 1'b0;
        step();
        check("stream_count_17cyc", out_cnt - start_cnt, 16);
        check("stream_empty_occ", {30'h0, occ}, 32'h0);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step();
        in_data = 8'h22;
        step();
        check("bp_occ_full", {30'h0, occ}, 32'h2);
        check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        check("bp_out_data", {24'h0, out_data}, 32'h11);
        in_data = 8'h33;
        step();
        step();
        check("bp_hold_occ", {30'h0, occ}, 32'h2);
        check("bp_hold_data", {24'h0, out_data}, 32'h11);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_drain1_data", {24'h0, out_data}, 32'h22);
        check("bp_drain1_occ", {30'h0, occ}, 32'h1);
        step();
        check("bp_drain2_valid", {31'h0, out_valid}, 32'h0);
        check("bp_drain2_occ", {30'h0, occ}, 32'h0);
        check("bp_queue_empty", exp_q.size(), 0);

        // Drain to empty leaves the stale word visible
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        check("drain_valid", {31'h0, out_valid}, 32'h1);
        check("drain_data", {24'h0, out_data}, 32'h5A);
        step();
        check("drain_valid_fall", {31'h0, out_valid}, 32'h0);
        check("drain_occ", {30'h0, occ}, 32'h0);
        check("drain_stale_data", {24'h0, out_data}, 32'h5A);

        // Random stalls
        chk_inv = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk_inv = 1'b0;
        check("rnd_queue_empty", exp_q.size(), 0);
        check("rnd_in_eq_out", out_cnt, in_cnt);
        check("rnd_occ_empty", {30'h0, occ}, 32'h0);

        // Async reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h66;
        step();
        in_data = 8'h67;
        step();
        check("ar_pre_occ", {30'h0, occ}, 32'h2);
        #2 arst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("ar_occ", {30'h0, occ}, 32'h0);
        check("ar_out_valid", {31'h0, out_valid}, 32'h0);
        check("ar_in_ready", {31'h0, in_ready}, 32'h1);
        check("ar_out_data", {24'h0, out_data}, {24'h0, PRESET});
        exp_q.delete();
        step();
        arst_n    = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        step();
        check("ar_first_valid", {31'h0, out_valid}, 32'h1);
        check("ar_first_data", {24'h0, out_data}, 32'h77);
        in_valid = 1'b0;
        step();
        check("ar_final_occ", {30'h0, occ}, 32'h0);
        check("ar_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_buf.md
Name: pipe_skid_buf

Overview:
- Two-entry valid/ready pipeline slice for datapath stages.
- Registers both the forward path (data/valid) and the backward path (ready), so timing is broken in both directions.
- Throughput is one word per cycle; latency is one cycle.
- Inserted between pipeline stages wherever the downstream stage can stall.

Parameters:
- DATA_W, 20: payload width in bits.
- PRESET_VAL, 0: reset value of both internal data registers, and therefore of out_data.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- arst_n, input, 1: reset, asynchronous and active-low; clears all state immediately.
- in_valid, input, 1: upstream has a word on in_data.
- in_ready, output, 1: buffer accepts a word this cycle; driven directly from a flop.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: out_data holds a valid word; driven directly from a flop.
- out_ready, input, 1: downstream accepts this cycle.
- out_data, output, DATA_W: payload; driven directly from the main data register.
- occ, output, 2: entries held (0, 1 or 2); for debug and verification.

Behaviour:
- Handshake firing:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Reset (arst_n=0, asynchronous):
  - state=EMPTY.
  - main_q = PRESET_VAL, skid_q = PRESET_VAL.
  - out_valid=0, in_ready=1, occ=0.
  - out_data=PRESET_VAL.
- Decoded outputs per state:
  - EMPTY: in_ready=1, out_valid=0, occ=0.
  - BUSY: in_ready=1, out_valid=1, occ=1.
  - FULL: in_ready=0, out_valid=1, occ=2.
  - State is encoded so that in_ready and out_valid come straight from flops, with no logic on out_ready to in_ready.
- Transitions:
  - EMPTY, in_fire: main_q<=in_data, go to BUSY. Otherwise stay; data is held.
  - BUSY, in_fire & out_fire: main_q<=in_data, stay BUSY (streaming).
  - BUSY, in_fire & !out_ready: skid_q<=in_data, go to FULL; main_q is held.
  - BUSY, !in_valid & out_fire: go to EMPTY; main_q is held (stale, not cleared).
  - BUSY, no fire: hold.
  - FULL, out_ready: main_q<=skid_q, go to BUSY.
  - FULL, !out_ready: hold. in_valid is ignored because in_ready=0.
- Latency: a word accepted at edge N is presented on out_data/out_valid after edge N.
- Ordering: strict FIFO order; no word is dropped or duplicated.
- out_data stability: stable while out_valid=1 and out_ready=0.
- in_data while in_ready=0: a change on in_data has no effect.
- Reset mid-transfer: all held words are discarded; outputs go to reset values without waiting for a clock edge.
- Deassertion of arst_n: on the following edge the buffer accepts a word if in_valid=1.
- No arithmetic; data is passed through unmodified at full DATA_W.

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants ST_EMPTY=2'b00, ST_BUSY=2'b01, ST_FULL=2'b11.
  - bit 0 of the encoding = out_valid; bit 1 of the encoding = !in_ready.
- Sub-module reg_arstn_en:
  - enabled data register with parameters DATA_W and PRESET_VAL, async active-low reset.
  - instantiated twice, as main_q and skid_q.
  - write enables and the input mux are generated in pipe_skid_buf.

Test Plan:
- Reset check: hold arst_n=0 with DATA_W=8, PRESET_VAL=8'hA5 -> out_valid=0, in_ready=1, occ=0, out_data=8'hA5, all without a clock edge.
- Streaming: drive 8'h01..8'h10 back-to-back with out_ready=1 -> out_data follows input one cycle later; occ stays 1; 16 words out in 17 cycles.
- Backpressure: send 8'h11, 8'h22 with out_ready=0 -> occ=2 and in_ready=0 from the following cycle; out_data=8'h11 is held. Change in_data to 8'h33 with in_valid=1 -> nothing is accepted. Raise out_ready -> outputs 8'h11 then 8'h22, then empty.
- Random stall: random in_valid/out_ready at 50% for 1000 cycles -> scoreboard shows the output sequence equals the input sequence, and no cycle has in_ready=0 with occ<2.
- Drain to empty: one word 8'h5A with out_ready=1 and in_valid dropped afterwards -> out_valid falls after one cycle; occ=0; out_data stays 8'h5A.
- Async reset mid-operation: assert arst_n=0 between edges while occ=2 -> occ=0, out_valid=0, in_ready=1 immediately. After release, new word 8'h77 is the first output.
